hs_serializer: RTL

HS_SERIALIZER -- requirements
Module: hs_serializer

---
 rtl/mipi_dphy_pkg.sv | 25 ++
 rtl/hs_serializer.sv | 104 ++++++++++
 2 files changed

// File: rtl/mipi_dphy_pkg.sv
// ============================================================================
// Module      : mipi_dphy_pkg
// Description : Shared D-PHY TX constants: HS serializer state encoding,
//               leader byte and trail length defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mipi_dphy_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_SYNC  = 2'd1;
    localparam state_t c_ST_DATA  = 2'd2;
    localparam state_t c_ST_TRAIL = 2'd3;

    // HS leader, transmitted LSB first as 0,0,0,1,1,1,0,1
    localparam logic [7:0]  c_SYNC_BYTE_DEF    = 8'hB8;
    localparam int unsigned c_TRAIL_CYCLES_DEF = 4;
    localparam int unsigned c_HS_BYTE_W        = 8;

endpackage

`default_nettype wire

// File: rtl/hs_serializer.sv
// ============================================================================
// Module      : hs_serializer
// Description : D-PHY HS byte serializer; emits two bits per clock (even/odd)
//               to the DDR output mux, framed by the leader byte and a trail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_serializer
    import mipi_dphy_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = c_SYNC_BYTE_DEF,
    parameter int unsigned TRAIL_CYCLES = c_TRAIL_CYCLES_DEF
) (
    input  logic       TxDDRClkHS,
    input  logic       TxRst,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic       serial_B1,
    output logic       serial_B2,
    output logic       SOT
);

    localparam logic [3:0] c_TRAIL_LOAD = 4'(TRAIL_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_slot;
    logic [3:0] r_trail_cnt;
    logic [7:0] r_shreg;
    logic       r_b1;
    logic       r_b2;
    logic       r_sot;

    assign TxReadyHS = ((r_state == c_ST_SYNC) || (r_state == c_ST_DATA)) && (r_slot == 2'd3);
    assign serial_B1 = r_b1;
    assign serial_B2 = r_b2;
    assign SOT       = r_sot;

    // The shift register rotates right by two per slot, so the pair for the
    // next slot always sits in bits [3:2] and the byte's bit 7 ends in bit 1.
    always_ff @(posedge TxDDRClkHS or posedge TxRst) begin
        if (TxRst) begin
            r_state     <= c_ST_IDLE;
            r_slot      <= 2'd0;
            r_trail_cnt <= 4'd0;
            r_shreg     <= 8'd0;
            r_b1        <= 1'b0;
            r_b2        <= 1'b0;
            r_sot       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (TxRequestHS) begin
                        r_state <= c_ST_SYNC;
                        r_slot  <= 2'd0;
                        r_shreg <= SYNC_BYTE;
                        r_b1    <= SYNC_BYTE[0];
                        r_b2    <= SYNC_BYTE[1];
                        r_sot   <= 1'b1;
                    end
                end
                c_ST_SYNC, c_ST_DATA: begin
                    if (r_slot != 2'd3) begin
                        r_slot  <= r_slot + 2'd1;
                        r_shreg <= {r_shreg[1:0], r_shreg[7:2]};
                        r_b1    <= r_shreg[2];
                        r_b2    <= r_shreg[3];
                    end else if (TxRequestHS) begin
                        r_state <= c_ST_DATA;
                        r_slot  <= 2'd0;
                        r_shreg <= TxDataHS;
                        r_b1    <= TxDataHS[0];
                        r_b2    <= TxDataHS[1];
                    end else begin
                        r_state     <= c_ST_TRAIL;
                        r_slot      <= 2'd0;
                        r_trail_cnt <= c_TRAIL_LOAD;
                        r_b1        <= ~r_shreg[1];
                        r_b2        <= ~r_shreg[1];
                    end
                end
                c_ST_TRAIL: begin
                    // Requests are ignored here; a new burst only starts from IDLE
                    if (r_trail_cnt == 4'd0) begin
                        r_state <= c_ST_IDLE;
                        r_shreg <= 8'd0;
                        r_b1    <= 1'b0;
                        r_b2    <= 1'b0;
                        r_sot   <= 1'b0;
                    end else begin
                        r_trail_cnt <= r_trail_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
